// File: rtl/debounce_pkg.sv
// Shared definitions for the push-button debouncer.
//   ch_state_e              : per-channel filter state encoding
//   DEBOUNCE_CYCLES_DEFAULT : stable samples needed before an output moves (10 ms at 50 MHz)
//   SYNC_STAGES_DEFAULT     : flops in each input synchroniser
//   BTN_RELEASED            : level of a released (active-low) button
package debounce_pkg;

    typedef enum logic [1:0] {
        StRel     = 2'b00,
        StWaitPrs = 2'b01,
        StPrs     = 2'b10,
        StWaitRel = 2'b11
    } ch_state_e;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;
    localparam int unsigned SYNC_STAGES_DEFAULT     = 2;
    localparam logic        BTN_RELEASED            = 1'b1;

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: input synchroniser, 4-state stability filter and sample counter.
// Optional feature macro: BUTTON_DEBOUNCER_PULSE_EN (adds press_pulse_o).
// Ports:
//   clk_i         system clock
//   reset_i       synchronous active-high reset
//   raw_n_i       raw asynchronous active-low button pin
//   btn_n_o       debounced active-low level, registered
//   press_pulse_o one-cycle high pulse as btn_n_o falls (only with the macro defined)
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic raw_n_i,
    output logic btn_n_o
`ifdef BUTTON_DEBOUNCER_PULSE_EN
    ,
    output logic press_pulse_o
`endif
);

    localparam int unsigned   CntW   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_n;
    ch_state_e              state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   out_q, out_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q <= {SYNC_STAGES{BTN_RELEASED}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_n_i};
        end
    end

    assign sync_n = sync_q[SYNC_STAGES-1];

    // cnt holds the number of consecutive differing samples seen so far in a WAIT state;
    // the entering sample counts as the first, so the last one arrives at CntMax.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StRel: begin
                if (sync_n != BTN_RELEASED) begin
                    state_d = StWaitPrs;
                    cnt_d   = CntOne;
                end else begin
                    cnt_d = '0;
                end
            end
            StWaitPrs: begin
                if (sync_n == BTN_RELEASED) begin
                    state_d = StRel;
                    cnt_d   = '0;
                end else if (cnt_q == CntMax) begin
                    state_d = StPrs;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StPrs: begin
                if (sync_n == BTN_RELEASED) begin
                    state_d = StWaitRel;
                    cnt_d   = CntOne;
                end else begin
                    cnt_d = '0;
                end
            end
            StWaitRel: begin
                if (sync_n != BTN_RELEASED) begin
                    state_d = StPrs;
                    cnt_d   = '0;
                end else if (cnt_q == CntMax) begin
                    state_d = StRel;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: begin
                state_d = StRel;
                cnt_d   = '0;
            end
        endcase
    end

    // Output is a register decoded from the current state, so it cannot glitch.
    assign out_d = ((state_q == StPrs) || (state_q == StWaitRel)) ? ~BTN_RELEASED
                                                                   : BTN_RELEASED;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StRel;
            cnt_q   <= '0;
            out_q   <= BTN_RELEASED;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign btn_n_o = out_q;

`ifdef BUTTON_DEBOUNCER_PULSE_EN
    logic pulse_q, pulse_d;

    // Fires on the same edge that drives out_q from released to pressed.
    assign pulse_d = (out_q == BTN_RELEASED) && (out_d != BTN_RELEASED);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= pulse_d;
        end
    end

    assign press_pulse_o = pulse_q;
`endif

endmodule

// File: rtl/button_debouncer.sv
// Debounces the two active-low push-buttons feeding the button FSM.
// Optional feature macro: BUTTON_DEBOUNCER_PULSE_EN (adds press1_pulse/press2_pulse).
// Ports:
//   clk          system clock
//   reset        synchronous active-high reset
//   btn1_raw_n   raw button 1 pin, active-low, asynchronous, bouncing
//   btn2_raw_n   raw button 2 pin, active-low, asynchronous, bouncing
//   button1      debounced button 1, active-low (0 = pressed)
//   button2      debounced button 2, active-low (0 = pressed)
//   press1_pulse one-cycle pulse as button1 falls (macro defined only)
//   press2_pulse one-cycle pulse as button2 falls (macro defined only)
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic btn1_raw_n,
    input  logic btn2_raw_n,
    output logic button1,
    output logic button2
`ifdef BUTTON_DEBOUNCER_PULSE_EN
    ,
    output logic press1_pulse,
    output logic press2_pulse
`endif
);

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_ch1 (
        .clk_i         (clk),
        .reset_i       (reset),
        .raw_n_i       (btn1_raw_n),
        .btn_n_o       (button1)
`ifdef BUTTON_DEBOUNCER_PULSE_EN
        ,
        .press_pulse_o (press1_pulse)
`endif
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_ch2 (
        .clk_i         (clk),
        .reset_i       (reset),
        .raw_n_i       (btn2_raw_n),
        .btn_n_o       (button2)
`ifdef BUTTON_DEBOUNCER_PULSE_EN
        ,
        .press_pulse_o (press2_pulse)
`endif
    );

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=8, SYNC_STAGES=2.
// With BUTTON_DEBOUNCER_PULSE_EN defined it also checks the press pulses every cycle.
module tb_button_debouncer;

    localparam int unsigned DebCycles  = 8;
    localparam int unsigned SyncStages = 2;
    // Inputs change just after an edge, so the first capture is one tick later.
    localparam int Lat = SyncStages + DebCycles + 1;

    logic clk = 1'b0;
    logic reset;
    logic btn1_raw_n;
    logic btn2_raw_n;
    logic button1;
    logic button2;
`ifdef BUTTON_DEBOUNCER_PULSE_EN
    logic press1_pulse;
    logic press2_pulse;
`endif

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    always #5 clk = ~clk;

    button_debouncer #(
        .DEBOUNCE_CYCLES (DebCycles),
        .SYNC_STAGES     (SyncStages)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .btn1_raw_n   (btn1_raw_n),
        .btn2_raw_n   (btn2_raw_n),
        .button1      (button1),
        .button2      (button2)
`ifdef BUTTON_DEBOUNCER_PULSE_EN
        ,
        .press1_pulse (press1_pulse),
        .press2_pulse (press2_pulse)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one clock, then check both outputs (and pulses when present).
    task automatic step_check(input string tag, input logic e1, input logic e2,
                              input logic p1, input logic p2);
        @(posedge clk);
        #1;
        check_eq({tag, ".button1"}, {31'd0, button1}, {31'd0, e1});
        check_eq({tag, ".button2"}, {31'd0, button2}, {31'd0, e2});
`ifdef BUTTON_DEBOUNCER_PULSE_EN
        check_eq({tag, ".pulse1"}, {31'd0, press1_pulse}, {31'd0, p1});
        check_eq({tag, ".pulse2"}, {31'd0, press2_pulse}, {31'd0, p2});
`else
        if (p1 || p2) begin
            // pulses not present in this build
        end
`endif
    endtask

    // Outputs must hold their old values for n-1 ticks and move on tick n exactly.
    task automatic settle(input string tag, input int n, input logic pre1, input logic pre2,
                          input logic post1, input logic post2);
        for (int i = 1; i <= n; i++) begin
            if (i < n) begin
                step_check(tag, pre1, pre2, 1'b0, 1'b0);
            end else begin
                step_check(tag, post1, post2, pre1 & ~post1, pre2 & ~post2);
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        btn1_raw_n = 1'b0;
        btn2_raw_n = 1'b0;

        // Reset with both pins pressed: outputs held released.
        for (int i = 0; i < 3; i++) step_check("reset", 1'b1, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        settle("post_reset_press", Lat, 1'b1, 1'b1, 1'b0, 1'b0);

        btn1_raw_n = 1'b1;
        btn2_raw_n = 1'b1;
        settle("release_both", Lat, 1'b0, 1'b0, 1'b1, 1'b1);

        // Bounce with 3-cycle runs never reaches the output.
        for (int i = 0; i < 30; i++) begin
            btn1_raw_n = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
            step_check("bounce", 1'b1, 1'b1, 1'b0, 1'b0);
        end
        btn1_raw_n = 1'b0;
        settle("bounce_settle", Lat, 1'b1, 1'b1, 1'b0, 1'b1);

        // Short release glitch while pressed is rejected.
        btn1_raw_n = 1'b1;
        for (int i = 0; i < 5; i++) step_check("rel_glitch", 1'b0, 1'b1, 1'b0, 1'b0);
        btn1_raw_n = 1'b0;
        for (int i = 0; i < 20; i++) step_check("rel_glitch_hold", 1'b0, 1'b1, 1'b0, 1'b0);
        // A real release needs a fresh full count after the glitch.
        btn1_raw_n = 1'b1;
        settle("release1", Lat, 1'b0, 1'b1, 1'b1, 1'b1);

        // Simultaneous press and release on both channels.
        btn1_raw_n = 1'b0;
        btn2_raw_n = 1'b0;
        settle("both_press", Lat, 1'b1, 1'b1, 1'b0, 1'b0);
        btn1_raw_n = 1'b1;
        btn2_raw_n = 1'b1;
        settle("both_release", Lat, 1'b0, 1'b0, 1'b1, 1'b1);

        // Reset while the press count sits at 5 aborts it.
        btn1_raw_n = 1'b0;
        for (int i = 0; i < 7; i++) step_check("pre_abort", 1'b1, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step_check("abort_reset", 1'b1, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        settle("abort_restart", Lat, 1'b1, 1'b1, 1'b0, 1'b1);
        btn1_raw_n = 1'b1;
        settle("abort_release", Lat, 1'b0, 1'b1, 1'b1, 1'b1);

        // Button 2 alone: pulse on press only.
        btn2_raw_n = 1'b0;
        settle("press2", Lat, 1'b1, 1'b1, 1'b1, 1'b0);
        btn2_raw_n = 1'b1;
        settle("release2", Lat, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step_check("idle", 1'b1, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
